// File: rtl/data_mem_responder.sv
// Data-side memory responder: word RAM with byte/half/word lane steering, range/alignment checks, first-fault capture.
// Latency: loads and exceptions combinational in the request cycle; stores and all status registers update on the next rising edge.
// Backpressure: none; while ready_o is low (zero-fill), requests are dropped and the response is forced to zero.
module data_mem_responder #(
  parameter int unsigned DEPTH          = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  instType_i,
  input  logic [31:0] dataAddress_i,
  input  logic [31:0] writeData_i,
  output logic [31:0] readData_o,
  output logic [31:0] memException_o,
  output logic        ready_o,
  output logic        faultValid_o,
  output logic [31:0] faultCause_o,
  output logic [31:0] faultAddr_o,
  input  logic        faultClear_i,
  output logic [31:0] loadCount_o,
  output logic [31:0] storeCount_o
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [32:0] SPAN = 33'(DEPTH) * 33'd4;

  localparam logic [31:0] EXC_NONE     = 32'd0;
  localparam logic [31:0] EXC_LD_MISAL = 32'd4;
  localparam logic [31:0] EXC_LD_FAULT = 32'd5;
  localparam logic [31:0] EXC_ST_MISAL = 32'd6;
  localparam logic [31:0] EXC_ST_FAULT = 32'd7;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q;
  logic          init_we;

  logic [31:0]   mem [DEPTH];

  logic          acc_vld, is_store, bad_size, misalign, out_of_range, fault;
  logic          good_load, good_store;
  logic [1:0]    size;
  logic [31:0]   offset, word, shifted, wdat, exc, rdata;
  logic [AW-1:0] widx;
  logic [3:0]    be;

  logic          fault_vld_q;
  logic [31:0]   fault_cause_q, fault_addr_q;
  logic [31:0]   load_cnt, store_cnt;

  // Word index derived from the byte offset; base is DEPTH*4 aligned so low offset bits equal address bits.
  assign offset = dataAddress_i - BASE_ADDR;
  assign widx   = offset[AW+1:2];
  assign word   = mem[widx];

  // State register: zero-fill after reset unless the fill is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT on the cycle the last word is cleared; RUN holds until reset.
  always_comb begin
    state_d = state_q;
    init_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        init_we = 1'b1;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Fill index walks the RAM one word per cycle while in INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (init_we) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // Request decode: bad size beats misalignment, misalignment beats range.
  always_comb begin
    acc_vld      = (state_q == ST_RUN) && instType_i[3];
    is_store     = instType_i[2];
    size         = instType_i[1:0];
    bad_size     = (size == 2'b11);
    misalign     = ((size == 2'b01) && offset[0]) ||
                   ((size == 2'b10) && (offset[1:0] != 2'b00));
    out_of_range = ({1'b0, offset} >= SPAN);
    fault        = acc_vld && (bad_size || misalign || out_of_range);
    good_load    = acc_vld && !is_store && !fault;
    good_store   = acc_vld && is_store && !fault;

    exc = EXC_NONE;
    if (acc_vld) begin
      if (bad_size)          exc = is_store ? EXC_ST_FAULT : EXC_LD_FAULT;
      else if (misalign)     exc = is_store ? EXC_ST_MISAL : EXC_LD_MISAL;
      else if (out_of_range) exc = is_store ? EXC_ST_FAULT : EXC_LD_FAULT;
    end

    shifted = word >> {offset[1:0], 3'b000};
    rdata   = '0;
    if (good_load) begin
      case (size)
        2'b00:   rdata = shifted & 32'h0000_00FF;
        2'b01:   rdata = shifted & 32'h0000_FFFF;
        2'b10:   rdata = word;
        default: rdata = '0;
      endcase
    end

    be   = 4'b0000;
    wdat = writeData_i;
    case (size)
      2'b00: begin
        be   = 4'b0001 << offset[1:0];
        wdat = {4{writeData_i[7:0]}};
      end
      2'b01: begin
        be   = offset[1] ? 4'b1100 : 4'b0011;
        wdat = {2{writeData_i[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    if (!good_store) begin
      be = 4'b0000;
    end
  end

  assign readData_o     = rdata;
  assign memException_o = exc;
  assign ready_o        = (state_q == ST_RUN);

  // RAM: zero-fill during INIT, otherwise per-lane store writes. Contents survive reset.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[idx_q] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[widx][8*i +: 8] <= wdat[8*i +: 8];
        end
      end
    end
  end

  // First-fault capture; a clear in the same cycle as a new fault re-arms onto that fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_vld_q   <= 1'b0;
      fault_cause_q <= '0;
      fault_addr_q  <= '0;
    end else if (fault && (!fault_vld_q || faultClear_i)) begin
      fault_vld_q   <= 1'b1;
      fault_cause_q <= exc;
      fault_addr_q  <= dataAddress_i;
    end else if (faultClear_i) begin
      fault_vld_q   <= 1'b0;
    end
  end

  // Completed-access counters, wrapping silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (good_load)  load_cnt  <= load_cnt + 32'd1;
      if (good_store) store_cnt <= store_cnt + 32'd1;
    end
  end

  assign faultValid_o = fault_vld_q;
  assign faultCause_o = fault_cause_q;
  assign faultAddr_o  = fault_addr_q;
  assign loadCount_o  = load_cnt;
  assign storeCount_o = store_cnt;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand sequences, random traffic vs a byte-array model.
// Latency: responses sampled 1 time unit after the negedge drive; registered state sampled 1 unit after posedge.
// Backpressure: none; ready_o is only observed for the zero-fill duration.
module tb_data_mem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int unsigned NBYTE = DEPTH * 4;

  localparam logic [3:0] LB = 4'b1000, LH = 4'b1001, LW = 4'b1010, LX = 4'b1011;
  localparam logic [3:0] SB = 4'b1100, SH = 4'b1101, SW = 4'b1110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  instType_i = '0;
  logic [31:0] dataAddress_i = '0;
  logic [31:0] writeData_i = '0;
  logic        faultClear_i = 1'b0;
  logic [31:0] readData_o, memException_o, faultCause_o, faultAddr_o, loadCount_o, storeCount_o;
  logic        ready_o, faultValid_o;

  int n_chk = 0;
  int n_fail = 0;

  data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .instType_i(instType_i), .dataAddress_i(dataAddress_i),
    .writeData_i(writeData_i), .readData_o(readData_o), .memException_o(memException_o),
    .ready_o(ready_o), .faultValid_o(faultValid_o), .faultCause_o(faultCause_o),
    .faultAddr_o(faultAddr_o), .faultClear_i(faultClear_i), .loadCount_o(loadCount_o),
    .storeCount_o(storeCount_o)
  );

  always #5 clk = ~clk;

  // Reference model: memory as a flat byte array, status as plain variables.
  logic [7:0]  mb [NBYTE];
  logic [31:0] m_loads, m_stores, m_fcause, m_faddr;
  logic        m_fvalid;

  function automatic void model_reset();
    for (int i = 0; i < int'(NBYTE); i++) mb[i] = 8'h00;
    m_loads = 0; m_stores = 0; m_fcause = 0; m_faddr = 0; m_fvalid = 1'b0;
  endfunction

  function automatic void model_step(input logic [3:0] inst, input logic [31:0] addr, input logic [31:0] wd,
                                     input logic clr, output logic [31:0] exc, output logic [31:0] rd);
    int unsigned nbytes;
    logic [31:0] off;
    exc = 0; rd = 0;
    nbytes = 1 << inst[1:0];
    off = addr - BASE;
    if (inst[3]) begin
      if (inst[1:0] == 2'b11)         exc = inst[2] ? 32'd7 : 32'd5;
      else if ((addr % nbytes) != 0)  exc = inst[2] ? 32'd6 : 32'd4;
      else if (off >= NBYTE)          exc = inst[2] ? 32'd7 : 32'd5;
      else if (inst[2]) begin
        for (int i = 0; i < int'(nbytes); i++) mb[off + i] = wd[8*i +: 8];
        m_stores = m_stores + 1;
      end else begin
        for (int i = 0; i < int'(nbytes); i++) rd = rd | (32'(mb[off + i]) << (8 * i));
        m_loads = m_loads + 1;
      end
    end
    if (exc != 0 && (!m_fvalid || clr)) begin
      m_fvalid = 1'b1; m_fcause = exc; m_faddr = addr;
    end else if (clr) begin
      m_fvalid = 1'b0;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One request cycle: combinational response checked mid-cycle, registered state after the edge.
  task automatic access(input logic [3:0] inst, input logic [31:0] addr, input logic [31:0] wd, input logic clr,
                        input bit use_tbl, input logic [31:0] t_rd, input logic [31:0] t_exc, input string nm);
    logic [31:0] e_exc, e_rd;
    @(negedge clk);
    instType_i = inst; dataAddress_i = addr; writeData_i = wd; faultClear_i = clr;
    #1;
    model_step(inst, addr, wd, clr, e_exc, e_rd);
    if (use_tbl) begin
      e_exc = t_exc; e_rd = t_rd;
    end
    chk({nm, " exc"}, memException_o, e_exc);
    chk({nm, " rd"}, readData_o, e_rd);
    @(posedge clk);
    #1;
    chk({nm, " loadCount"}, loadCount_o, m_loads);
    chk({nm, " storeCount"}, storeCount_o, m_stores);
    chk({nm, " faultValid"}, 32'(faultValid_o), 32'(m_fvalid));
    chk({nm, " faultCause"}, faultCause_o, m_fcause);
    chk({nm, " faultAddr"}, faultAddr_o, m_faddr);
  endtask

  task automatic measure_ready(input string nm);
    int cyc;
    cyc = 0;
    while (!ready_o && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(nm, 32'(cyc), 32'd16);
  endtask

  typedef struct {
    logic [3:0]  inst;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exc;
  } vec_t;

  vec_t tbl [14];

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_st;
    tbl[0]  = '{SW, BASE + 8,  32'hDEAD_BEEF, 32'h0,         32'd0};
    tbl[1]  = '{SB, BASE + 9,  32'h0000_0011, 32'h0,         32'd0};
    tbl[2]  = '{SH, BASE + 10, 32'h0000_2233, 32'h0,         32'd0};
    tbl[3]  = '{LW, BASE + 8,  32'h0,         32'h2233_11EF, 32'd0};
    tbl[4]  = '{LB, BASE + 11, 32'h0,         32'h0000_0022, 32'd0};
    tbl[5]  = '{LH, BASE + 8,  32'h0,         32'h0000_11EF, 32'd0};
    tbl[6]  = '{LH, BASE + 1,  32'h0,         32'h0,         32'd4};
    tbl[7]  = '{SW, BASE + 2,  32'hFFFF_FFFF, 32'h0,         32'd6};
    tbl[8]  = '{LW, BASE + 0,  32'h0,         32'h0,         32'd0};
    tbl[9]  = '{LW, BASE + NBYTE, 32'h0,      32'h0,         32'd5};
    tbl[10] = '{SW, BASE - 4,  32'h1234_5678, 32'h0,         32'd7};
    tbl[11] = '{LW, BASE + NBYTE - 4, 32'h0,  32'h0,         32'd0};
    tbl[12] = '{LX, BASE,      32'h0,         32'h0,         32'd5};
    tbl[13] = '{LB, BASE + 10, 32'h0,         32'h0000_0033, 32'd0};

    // Reset state and zero-fill duration.
    #12;
    chk("reset ready", 32'(ready_o), 32'd0);
    chk("reset faultValid", 32'(faultValid_o), 32'd0);
    chk("reset loadCount", loadCount_o, 32'd0);
    chk("reset storeCount", storeCount_o, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    measure_ready("init cycles");

    // Requests during INIT are ignored; a reset pulse mid-fill restarts it.
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("rereset ready", 32'(ready_o), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instType_i = SW; dataAddress_i = BASE; writeData_i = 32'hFFFF_FFFF;
      #1;
      chk("init exc", memException_o, 32'd0);
      chk("init rd", readData_o, 32'd0);
      chk("init ready", 32'(ready_o), 32'd0);
      @(posedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("pulse ready", 32'(ready_o), 32'd0);
    instType_i = '0;
    @(negedge clk) rst_n = 1'b1;
    measure_ready("init cycles after pulse");
    chk("post-init storeCount", storeCount_o, 32'd0);
    model_reset();

    for (int w = 0; w < int'(DEPTH); w++)
      access(LW, BASE + 32'(4 * w), 32'h0, 1'b0, 1'b1, 32'h0, 32'd0, $sformatf("zero w%0d", w));

    // Directed vectors: lane steering, misalignment, range, reserved size.
    for (int i = 0; i < 14; i++)
      access(tbl[i].inst, tbl[i].addr, tbl[i].wd, 1'b0, 1'b1, tbl[i].rd, tbl[i].exc, $sformatf("vec%0d", i));
    chk("first fault cause", faultCause_o, 32'd4);
    chk("first fault addr", faultAddr_o, BASE + 1);

    // Clear coinciding with a new fault captures the new one; clear alone drops valid only.
    access(SB, BASE - 1, 32'h55, 1'b1, 1'b1, 32'h0, 32'd7, "clr+fault");
    chk("clr+fault valid", 32'(faultValid_o), 32'd1);
    chk("clr+fault cause", faultCause_o, 32'd7);
    chk("clr+fault addr", faultAddr_o, BASE - 1);
    access(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0, 32'd0, "clr only");
    chk("clr only valid", 32'(faultValid_o), 32'd0);
    chk("clr only stale cause", faultCause_o, 32'd7);

    // Load counter wrap; faulting and idle cycles leave counters alone.
    @(negedge clk);
    instType_i = '0; faultClear_i = 1'b0;
    force dut.load_cnt = 32'hFFFF_FFFF;
    #1 release dut.load_cnt;
    m_loads = 32'hFFFF_FFFF;
    #1;
    chk("forced loadCount", loadCount_o, 32'hFFFF_FFFF);
    saved_st = storeCount_o;
    access(LW, BASE + 8, 32'h0, 1'b0, 1'b1, 32'h2233_11EF, 32'd0, "wrap load");
    chk("wrapped loadCount", loadCount_o, 32'd0);
    access(LH, BASE + 3, 32'h0, 1'b0, 1'b1, 32'h0, 32'd4, "fault load");
    access(4'b0110, BASE + 4, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0, 32'd0, "idle store bits");
    chk("idle loadCount", loadCount_o, 32'd0);
    chk("idle storeCount", storeCount_o, saved_st);

    // Random traffic against the byte-array model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0]  inst;
      logic [31:0] addr, wd;
      logic        clr;
      int unsigned r, nb;
      inst[3] = ($urandom_range(0, 9) != 0);
      inst[2] = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      inst[1:0] = (r < 5) ? 2'b00 : (r < 10) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
      nb = 1 << inst[1:0];
      r = $urandom_range(0, 9);
      if (r == 0)      addr = BASE - 32'd16 + 32'($urandom_range(0, 15));
      else if (r == 1) addr = BASE + NBYTE + 32'($urandom_range(0, 15));
      else begin
        addr = BASE + 32'($urandom_range(0, NBYTE - 1));
        if ($urandom_range(0, 3) != 0 && nb < 8) addr = addr & ~(32'(nb) - 32'd1);
      end
      wd  = $urandom;
      clr = ($urandom_range(0, 7) == 0);
      access(inst, addr, wd, clr, 1'b0, 32'h0, 32'h0, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
